// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch stage.
// Keeps up to MAX_OUTSTANDING reads in flight to instruction memory and buffers
// returned words in a DEPTH-entry queue ahead of a registered decode output.
// A redirect flushes the queue, restarts fetch at redirect_pc and drops the
// responses of reads that were already in flight.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   redirect            one-cycle PC change request, redirect_pc = new address
//   address_enable      read request issued this cycle, address = read address
//   data_valid, data    in-order read response from memory
//   hold                decode stall, freezes the valid output
//   is_valid            instruction/pc valid to decode
//   instruction, pc     fetched word and its address
//   queue_count         occupied queue entries
module fetch_queue #(
    parameter int unsigned      WIDTH           = 32,
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter int unsigned      PC_STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_PC        = '0,
    parameter logic [WIDTH-1:0] NOP_WORD        = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    output logic                       address_enable,
    output logic [WIDTH-1:0]           address,
    input  logic                       data_valid,
    input  logic [WIDTH-1:0]           data,
    input  logic                       hold,
    output logic                       is_valid,
    output logic [WIDTH-1:0]           instruction,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [WIDTH-1:0] r_fetch_pc;
    logic [OW-1:0]    r_outstanding;
    logic [OW-1:0]    r_discard;

    logic [WIDTH-1:0] r_tag [MAX_OUTSTANDING];
    logic [TW-1:0]    r_tag_wr;
    logic [TW-1:0]    r_tag_rd;

    logic [WIDTH-1:0] r_q_data [DEPTH];
    logic [WIDTH-1:0] r_q_pc   [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_valid;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc;

    logic             w_issue;
    logic             w_resp;
    logic             w_push;
    logic             w_load;
    logic             w_pop;
    logic [31:0]      w_live;

    // Tag FIFO depth need not be a power of two, so wrap explicitly.
    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    // Queue entries plus every request whose response will be kept: issuing
    // only below DEPTH guarantees a response always finds a free slot.
    assign w_live  = 32'(r_count) + 32'(r_outstanding) - 32'(r_discard);
    assign w_issue = !reset && !redirect && (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                     && (w_live < 32'(DEPTH));
    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_resp  = data_valid && (r_outstanding != '0);
    assign w_push  = w_resp && !redirect && (r_discard == '0);
    assign w_load  = !r_valid || !hold;
    assign w_pop   = w_load && (r_count != '0) && !redirect;

    assign address_enable = w_issue;
    assign address        = r_fetch_pc;
    assign is_valid       = r_valid;
    assign instruction    = r_instr;
    assign pc             = r_pc;
    assign queue_count    = r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_valid       <= 1'b0;
            r_instr       <= NOP_WORD;
            r_pc          <= '0;
        end else begin
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + WIDTH'(PC_STEP);
            end

            case ({w_issue, w_resp})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: ;
            endcase

            // Everything still in flight after this cycle is stale.
            if (redirect) begin
                r_discard <= r_outstanding - OW'(w_resp);
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - OW'(1);
            end

            if (w_issue) r_tag_wr <= tag_next(r_tag_wr);
            if (w_resp)  r_tag_rd <= tag_next(r_tag_rd);

            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end

            // Redirect overrides hold; an empty queue keeps the last word/pc.
            if (redirect) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= (r_count != '0);
                if (r_count != '0) begin
                    r_instr <= r_q_data[r_rd_ptr];
                    r_pc    <= r_q_pc[r_rd_ptr];
                end
            end
        end
    end

    // Payload storage needs no reset; validity is carried by the pointers.
    always_ff @(posedge clock) begin
        if (w_issue) r_tag[r_tag_wr] <= r_fetch_pc;
        if (w_push) begin
            r_q_data[r_wr_ptr] <= data;
            r_q_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: randomized memory latency, hold and
// redirects, checked against a sequential-PC reference stream.
module tb_fetch_queue;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAXO     = 2;
    localparam int unsigned STEP     = 4;
    localparam logic [31:0] RST_PC   = 32'hFFFF_FFF0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        address_enable;
    logic [31:0] address;
    logic        data_valid;
    logic [31:0] data;
    logic        hold;
    logic        is_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [2:0]  queue_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit fast  = 1'b1;

    fetch_queue #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .PC_STEP        (STEP),
        .RESET_PC       (RST_PC),
        .NOP_WORD       (NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .address_enable(address_enable),
        .address       (address),
        .data_valid    (data_valid),
        .data          (data),
        .hold          (hold),
        .is_valid      (is_valid),
        .instruction   (instruction),
        .pc            (pc),
        .queue_count   (queue_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
        end
    endtask

    // Memory model: in-order responses, latency 1..4 cycles (1 when fast).
    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;
    req_t        pend[$];
    logic [31:0] exp_addr;
    bit          saw_reset = 1'b0;

    initial begin
        data_valid = 1'b0;
        data       = '0;
        exp_addr   = RST_PC;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend.delete();
                exp_addr  = RST_PC;
                saw_reset = 1'b1;
            end else begin
                if (address_enable) begin
                    check("issue_addr", address, exp_addr);
                    exp_addr += STEP;
                    pend.push_back('{a: address,
                                     due: cyc + (fast ? 1 : int'($urandom_range(1, 4)))});
                end
                if (redirect) begin
                    check("no_issue_on_redirect", 32'(address_enable), 32'd0);
                    exp_addr = redirect_pc;
                end
                check("outstanding_bound", 32'(pend.size() <= MAXO), 32'd1);
            end
            @(posedge clock);
            #1;
            if (saw_reset) begin
                // Stray response straddling reset release must be ignored.
                data_valid = 1'b1;
                data       = $urandom;
                saw_reset  = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                data_valid = 1'b1;
                data       = ref_word(pend[0].a);
                void'(pend.pop_front());
            end else if (pend.size() == 0 && $urandom_range(0, 15) == 0) begin
                data_valid = 1'b1;
                data       = $urandom;
            end else begin
                data_valid = 1'b0;
                data       = $urandom;
            end
        end
    end

    // Scoreboard: expected pcs decode should consume, in order.
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;

    task automatic rebuild(input logic [31:0] start);
        exp_q.delete();
        exp_q.push_back(start);
        exp_tail = start;
    endtask

    initial begin
        logic        pv;
        logic        ph;
        logic        prd;
        logic [31:0] pi;
        logic [31:0] pp;
        logic [31:0] e;
        pv  = 1'b0;
        ph  = 1'b0;
        prd = 1'b0;
        pi  = '0;
        pp  = '0;
        rebuild(RST_PC);
        forever begin
            @(negedge clock);
            if (reset) begin
                check("rst_valid", 32'(is_valid), 32'd0);
                check("rst_instr", instruction, NOP);
                check("rst_pc", pc, 32'd0);
                check("rst_count", 32'(queue_count), 32'd0);
                check("rst_addr_en", 32'(address_enable), 32'd0);
                rebuild(RST_PC);
                pv  = 1'b0;
                prd = 1'b0;
            end else begin
                check("count_bound", 32'(queue_count <= DEPTH), 32'd1);
                if (prd) check("invalid_after_redirect", 32'(is_valid), 32'd0);
                if (pv && ph && !prd) begin
                    check("hold_valid", 32'(is_valid), 32'd1);
                    check("hold_instr", instruction, pi);
                    check("hold_pc", pc, pp);
                end
                while (exp_q.size() < 4) begin
                    exp_tail += STEP;
                    exp_q.push_back(exp_tail);
                end
                if (is_valid && !hold) begin
                    e = exp_q.pop_front();
                    check("out_pc", pc, e);
                    check("out_instr", instruction, ref_word(e));
                end
                if (redirect) rebuild(redirect_pc);
                pv  = is_valid;
                ph  = hold;
                prd = redirect;
                pi  = instruction;
                pp  = pc;
            end
        end
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        hold        = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        // Streaming, latency 1: first word visible three cycles after release.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("stream_valid", 32'(is_valid), 32'(i >= 3));
        end

        // Long hold fills the queue and stops issue.
        @(posedge clock);
        #1 hold = 1'b1;
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("hold_full_count", 32'(queue_count), DEPTH);
        check("hold_no_issue", 32'(address_enable), 32'd0);
        @(posedge clock);
        #1 hold = 1'b0;

        // Randomized traffic with redirects and holds.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock);
            #1;
            if (i % 50 == 0) fast = ($urandom_range(0, 3) == 0);
            hold     = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'h0000_0100;
                1:       redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = $urandom & 32'hFFFF_FFFC;
            endcase
        end

        // Asynchronous reset between edges takes effect immediately.
        @(posedge clock);
        #1;
        redirect = 1'b0;
        hold     = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(is_valid), 32'd0);
        check("async_rst_instr", instruction, NOP);
        check("async_rst_addr_en", 32'(address_enable), 32'd0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #1;
            hold     = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 30) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
        end
        @(posedge clock);
        #1;
        hold     = 1'b0;
        redirect = 1'b0;
        repeat (30) @(posedge clock);
        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
